wasm_lsu: RTL and testbench
===========================

// Module: wasm_lsu
// PURPOSE
//  Load/store initiator between the WASM execute stage and linear memory (or its AXI-lite adapter).
//  - Takes one memory command at a time: load, store, memory.size or memory.grow.
//  - Computes the effective address, drives mem_bus_req_t and mem_mgmt_req_t, and collects the response.
//  - Returns one result (data or trap) per command.
// PARAMETERS
//  none (all widths come from wasm_pkg)
// PORTS
//  clk          in   1      clock; single clock domain
//  rst_n        in   1      reset, asynchronous, active-low
//  cmd_valid    in   1      command present
//  cmd_ready    out  1      LSU idle, command accepted on cmd_valid&&cmd_ready
//  cmd_kind     in   lsu_kind_t  LSU_LOAD / LSU_STORE / LSU_SIZE / LSU_GROW
//  cmd_op       in   mem_op_t    load/store opcode (sign/size)
//  cmd_base     in   32     address operand popped from stack
//  cmd_offset   in   32     memarg offset immediate
//  cmd_wdata    in   64     store value; grow page delta in [31:0]
//  res_valid    out  1      result present; held until res_ready
//  res_ready    in   1      consumer accepts result
//  res_data     out  64     load data (extended), size/grow result zero-extended
//  res_trap     out  trap_t TRAP_NONE or TRAP_OUT_OF_BOUNDS
//  mem_req_o    out  mem_bus_req_t   valid/write/addr/size/wdata
//  mem_resp_i   in   mem_bus_resp_t  ready/rvalid/rdata/error
//  mem_op_o     out  mem_op_t        opcode alongside request (responder sign-extends)
//  mem_mgmt_req_o  out  mem_mgmt_req_t   grow_valid/grow_pages; init_valid tied 0
//  mem_mgmt_resp_i in   mem_mgmt_resp_t  current_pages/grow_result/grow_done
// BEHAVIOUR
//  - Reset: state IDLE; cmd_ready=1; res_valid=0; res_data=0; res_trap=TRAP_NONE; all req fields 0.
//  - Reset mid-operation: in-flight access is abandoned and no result is produced.
//    A grow already pulsed may still have taken effect in memory.
//  - FSM states: IDLE, REQ, WAIT, GROW, GROW_WAIT, RESP.
//  - IDLE, on accept: register the command.
//    - ea = {1'b0,base}+offset (33-bit).
//    - LOAD/STORE with ea[32]=1 -> RESP, trap=TRAP_OUT_OF_BOUNDS, no bus request ever issued.
//    - Otherwise LOAD/STORE -> REQ.
//    - LSU_SIZE -> RESP, res_data = current_pages sampled at the accept edge.
//    - LSU_GROW -> GROW.
//  - REQ: mem_req_o.valid=1 with registered fields, stable until mem_resp_i.ready.
//    - addr = ea[31:0]; size = mem_op_size(cmd_op); write = (kind==STORE).
//    - wdata = cmd_wdata with bytes above the access size forced to 0.
//    - On a ready cycle, store: done -> RESP; trap = error ? OUT_OF_BOUNDS : NONE.
//    - On a ready cycle, load with rvalid|error in the same cycle -> RESP (combinational responder).
//    - On a ready cycle, load otherwise -> WAIT.
//    - !ready: stay in REQ (valid held).
//  - WAIT: valid=0; rvalid -> RESP with rdata; error -> RESP with trap; rdata ignored.
//  - GROW: grow_valid=1 for exactly one cycle, grow_pages = cmd_wdata[31:0] -> GROW_WAIT.
//  - GROW_WAIT: on grow_done -> RESP, res_data = {32'b0, grow_result}.
//    Failure (FFFF_FFFF) is a normal result, not a trap.
//  - RESP: res_valid=1, outputs stable; on res_ready -> IDLE.
//  - cmd_ready=1 only in IDLE. No back-to-back overlap: at most one command is outstanding.
//  - Load latency: cmd accept at edge 0; req valid in cycle 1; res_valid in cycle 2 with a 0-wait responder.
//  - res_data when trapping = 0. Trap is reported only through res_trap, never by stalling.
//  - Address wrap: ea[32] overflow traps; wrap into low memory is forbidden.
// STRUCTURE
//  - wasm_pkg additions:
//    - lsu_kind_t enum.
//    - function mem_op_size(mem_op_t)->mem_size_t.
//    - function mem_op_is_store(mem_op_t).
//  - Single module, no sub-module; the FSM and the 33-bit adder are inline.
// TESTING
//  - i32.store base=0x10 off=4 wdata=0xDEADBEEF, then i32.load same ea -> 0x00000000DEADBEEF, TRAP_NONE.
//  - i32.load8_s at a byte=0x80 -> 0xFFFFFFFFFFFFFF80; i32.load8_u same byte -> 0x80.
//  - base=0xFFFFFFF0 off=0x20 -> TRAP_OUT_OF_BOUNDS, mem_req_o.valid never 1.
//  - Load at ea = pages*65536-2 size 4 -> responder error -> TRAP_OUT_OF_BOUNDS, res_data=0.
//  - 1 page, grow delta 2 -> 1 returned, then size -> 3; grow past max -> 0xFFFFFFFF, no trap.
//  - Stalling responder (ready low 3 cycles, rvalid 2 later): req fields stable, single result.
//  - Reset asserted mid-WAIT returns to IDLE with no res_valid.

Source files
------------

// File: rtl/wasm_pkg.sv
// Purpose: shared types and helpers for the WASM load/store path and linear-memory interfaces.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents: lsu_kind_t, mem_op_t, mem_size_t, trap_t, bus and memory-management
// request/response structs, and opcode decode helpers.
package wasm_pkg;

    typedef enum logic [1:0] {
        LSU_LOAD  = 2'd0,
        LSU_STORE = 2'd1,
        LSU_SIZE  = 2'd2,
        LSU_GROW  = 2'd3
    } lsu_kind_t;

    typedef enum logic [4:0] {
        OP_I32_LOAD     = 5'd0,
        OP_I64_LOAD     = 5'd1,
        OP_I32_LOAD8_S  = 5'd2,
        OP_I32_LOAD8_U  = 5'd3,
        OP_I32_LOAD16_S = 5'd4,
        OP_I32_LOAD16_U = 5'd5,
        OP_I64_LOAD8_S  = 5'd6,
        OP_I64_LOAD8_U  = 5'd7,
        OP_I64_LOAD16_S = 5'd8,
        OP_I64_LOAD16_U = 5'd9,
        OP_I64_LOAD32_S = 5'd10,
        OP_I64_LOAD32_U = 5'd11,
        OP_I32_STORE    = 5'd12,
        OP_I64_STORE    = 5'd13,
        OP_I32_STORE8   = 5'd14,
        OP_I32_STORE16  = 5'd15,
        OP_I64_STORE8   = 5'd16,
        OP_I64_STORE16  = 5'd17,
        OP_I64_STORE32  = 5'd18
    } mem_op_t;

    // Access size as log2(bytes).
    typedef enum logic [1:0] {
        SZ_1 = 2'd0,
        SZ_2 = 2'd1,
        SZ_4 = 2'd2,
        SZ_8 = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        TRAP_NONE          = 2'd0,
        TRAP_OUT_OF_BOUNDS = 2'd1
    } trap_t;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        mem_size_t   size;
        logic [63:0] wdata;
    } mem_bus_req_t;

    typedef struct packed {
        logic        ready;
        logic        rvalid;
        logic [63:0] rdata;
        logic        error;
    } mem_bus_resp_t;

    typedef struct packed {
        logic        grow_valid;
        logic [31:0] grow_pages;
        logic        init_valid;
    } mem_mgmt_req_t;

    typedef struct packed {
        logic [31:0] current_pages;
        logic [31:0] grow_result;
        logic        grow_done;
    } mem_mgmt_resp_t;

    function automatic mem_size_t mem_op_size(input mem_op_t op);
        mem_size_t sz;
        sz = SZ_4;
        case (op)
            OP_I32_LOAD8_S, OP_I32_LOAD8_U, OP_I64_LOAD8_S, OP_I64_LOAD8_U,
            OP_I32_STORE8, OP_I64_STORE8:                     sz = SZ_1;
            OP_I32_LOAD16_S, OP_I32_LOAD16_U, OP_I64_LOAD16_S, OP_I64_LOAD16_U,
            OP_I32_STORE16, OP_I64_STORE16:                   sz = SZ_2;
            OP_I64_LOAD, OP_I64_STORE:                        sz = SZ_8;
            default:                                          sz = SZ_4;
        endcase
        return sz;
    endfunction

    function automatic logic mem_op_is_store(input mem_op_t op);
        return (op == OP_I32_STORE)   || (op == OP_I64_STORE)   ||
               (op == OP_I32_STORE8)  || (op == OP_I32_STORE16) ||
               (op == OP_I64_STORE8)  || (op == OP_I64_STORE16) ||
               (op == OP_I64_STORE32);
    endfunction

    // Zero the bytes of a store value that lie above the access size.
    function automatic logic [63:0] store_data_mask(input logic [63:0] w, input mem_size_t sz);
        logic [63:0] m;
        m = w;
        case (sz)
            SZ_1:    m = {56'd0, w[7:0]};
            SZ_2:    m = {48'd0, w[15:0]};
            SZ_4:    m = {32'd0, w[31:0]};
            default: m = w;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/wasm_lsu.sv
// Purpose: load/store initiator between the WASM execute stage and linear memory.
// Latency: load with a zero-wait responder: accept at edge 0, request in cycle 1, result in cycle 2.
// Backpressure: one command outstanding; cmd_ready only when idle; result held until res_ready.
//
// Ports: clk/rst_n; cmd_* (valid/ready command: kind, op, base, offset, wdata);
// res_* (valid/ready result: data, trap); mem_req_o/mem_resp_i + mem_op_o (memory bus);
// mem_mgmt_req_o/mem_mgmt_resp_i (memory.grow / memory.size).
module wasm_lsu
    import wasm_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  lsu_kind_t      cmd_kind,
    input  mem_op_t        cmd_op,
    input  logic [31:0]    cmd_base,
    input  logic [31:0]    cmd_offset,
    input  logic [63:0]    cmd_wdata,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [63:0]    res_data,
    output trap_t          res_trap,
    output mem_bus_req_t   mem_req_o,
    input  mem_bus_resp_t  mem_resp_i,
    output mem_op_t        mem_op_o,
    output mem_mgmt_req_t  mem_mgmt_req_o,
    input  mem_mgmt_resp_t mem_mgmt_resp_i
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_WAIT      = 3'd2,
        S_GROW      = 3'd3,
        S_GROW_WAIT = 3'd4,
        S_RESP      = 3'd5
    } lsu_state_t;

    lsu_state_t  state_q, state_d;

    lsu_kind_t   kind_q;
    mem_op_t     op_q;
    logic [31:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] res_data_q;
    trap_t       res_trap_q;

    // 33-bit effective address: a carry out means the access wrapped past 4 GiB,
    // which is always out of bounds rather than an alias into low memory.
    logic [32:0] ea;
    assign ea = {1'b0, cmd_base} + {1'b0, cmd_offset};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cmd_ready      = 1'b0;
        res_valid      = 1'b0;
        mem_req_o      = '0;
        mem_mgmt_req_o = '0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_kind)
                        LSU_LOAD, LSU_STORE: state_d = ea[32] ? S_RESP : S_REQ;
                        LSU_SIZE:            state_d = S_RESP;
                        LSU_GROW:            state_d = S_GROW;
                    endcase
                end
            end
            S_REQ: begin
                mem_req_o.valid = 1'b1;
                mem_req_o.write = (kind_q == LSU_STORE);
                mem_req_o.addr  = addr_q;
                mem_req_o.size  = mem_op_size(op_q);
                mem_req_o.wdata = store_data_mask(wdata_q, mem_op_size(op_q));
                if (mem_resp_i.ready) begin
                    // A combinational responder may answer a load in the accept cycle.
                    if ((kind_q == LSU_STORE) || mem_resp_i.rvalid || mem_resp_i.error) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_resp_i.rvalid || mem_resp_i.error) begin
                    state_d = S_RESP;
                end
            end
            S_GROW: begin
                mem_mgmt_req_o.grow_valid = 1'b1;
                mem_mgmt_req_o.grow_pages = wdata_q[31:0];
                state_d                   = S_GROW_WAIT;
            end
            S_GROW_WAIT: begin
                if (mem_mgmt_resp_i.grow_done) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Command capture and result collection. The result registers are cleared on
    // accept so a trapping command always reports zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind_q     <= LSU_LOAD;
            op_q       <= OP_I32_LOAD;
            addr_q     <= '0;
            wdata_q    <= '0;
            res_data_q <= '0;
            res_trap_q <= TRAP_NONE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        kind_q     <= cmd_kind;
                        op_q       <= cmd_op;
                        addr_q     <= ea[31:0];
                        wdata_q    <= cmd_wdata;
                        res_data_q <= '0;
                        res_trap_q <= TRAP_NONE;
                        if (cmd_kind == LSU_SIZE) begin
                            res_data_q <= {32'd0, mem_mgmt_resp_i.current_pages};
                        end else if (((cmd_kind == LSU_LOAD) || (cmd_kind == LSU_STORE)) && ea[32]) begin
                            res_trap_q <= TRAP_OUT_OF_BOUNDS;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_resp_i.ready) begin
                        if (mem_resp_i.error) begin
                            res_trap_q <= TRAP_OUT_OF_BOUNDS;
                        end else if ((kind_q == LSU_LOAD) && mem_resp_i.rvalid) begin
                            res_data_q <= mem_resp_i.rdata;
                        end
                    end
                end
                S_WAIT: begin
                    // Error wins over rvalid; its rdata is not meaningful.
                    if (mem_resp_i.error) begin
                        res_trap_q <= TRAP_OUT_OF_BOUNDS;
                    end else if (mem_resp_i.rvalid) begin
                        res_data_q <= mem_resp_i.rdata;
                    end
                end
                S_GROW_WAIT: begin
                    // A failed grow (all ones) is an ordinary result, not a trap.
                    if (mem_mgmt_resp_i.grow_done) begin
                        res_data_q <= {32'd0, mem_mgmt_resp_i.grow_result};
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_data = res_data_q;
    assign res_trap = res_trap_q;
    assign mem_op_o = op_q;

endmodule

// File: tb/tb_wasm_lsu.sv
// Purpose: self-checking bench for wasm_lsu with a byte-memory responder and grow model.
// Latency: responder is zero-wait combinational, or stalling (ready after 3 cycles, rvalid later).
// Backpressure: bench holds one command at a time and pulses res_ready once per result.
module tb_wasm_lsu;
    import wasm_pkg::*;

    localparam int MAX_PAGES = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    lsu_kind_t      cmd_kind = LSU_LOAD;
    mem_op_t        cmd_op = OP_I32_LOAD;
    logic [31:0]    cmd_base = '0;
    logic [31:0]    cmd_offset = '0;
    logic [63:0]    cmd_wdata = '0;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [63:0]    res_data;
    trap_t          res_trap;
    mem_bus_req_t   mem_req_o;
    mem_bus_resp_t  mem_resp;
    mem_op_t        mem_op_o;
    mem_mgmt_req_t  mgmt_req;
    mem_mgmt_resp_t mgmt_resp;

    wasm_lsu dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_kind        (cmd_kind),
        .cmd_op          (cmd_op),
        .cmd_base        (cmd_base),
        .cmd_offset      (cmd_offset),
        .cmd_wdata       (cmd_wdata),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_data        (res_data),
        .res_trap        (res_trap),
        .mem_req_o       (mem_req_o),
        .mem_resp_i      (mem_resp),
        .mem_op_o        (mem_op_o),
        .mem_mgmt_req_o  (mgmt_req),
        .mem_mgmt_resp_i (mgmt_resp)
    );

    always #5 clk = ~clk;

    // ---------------- responder / memory model ----------------
    logic [7:0]  mem [0:1023];
    logic [31:0] pages;
    bit          stall_mode = 1'b0;
    int          rv_wait = 1;
    int          stall_cnt;
    logic        pend;
    int          pend_cnt;
    logic [63:0] pend_data;
    logic        pend_err;
    logic        gdone;
    logic [31:0] gres;

    function automatic logic oob(input logic [31:0] a, input mem_size_t s);
        return ({32'd0, a} + (64'd1 << s)) > ({32'd0, pages} << 16);
    endfunction

    function automatic logic [63:0] rd_ext(input logic [31:0] a, input mem_op_t op);
        logic [63:0] raw;
        logic [63:0] r;
        raw = '0;
        for (int i = 0; i < 8; i++) raw[i*8 +: 8] = mem[a[9:0] + 10'(i)];
        case (op)
            OP_I64_LOAD:                      r = raw;
            OP_I32_LOAD8_S, OP_I64_LOAD8_S:   r = {{56{raw[7]}}, raw[7:0]};
            OP_I32_LOAD8_U, OP_I64_LOAD8_U:   r = {56'd0, raw[7:0]};
            OP_I32_LOAD16_S, OP_I64_LOAD16_S: r = {{48{raw[15]}}, raw[15:0]};
            OP_I32_LOAD16_U, OP_I64_LOAD16_U: r = {48'd0, raw[15:0]};
            OP_I64_LOAD32_S:                  r = {{32{raw[31]}}, raw[31:0]};
            default:                          r = {32'd0, raw[31:0]};
        endcase
        return r;
    endfunction

    always_comb begin
        mem_resp = '0;
        if (mem_req_o.valid) begin
            if (!stall_mode) begin
                mem_resp.ready = 1'b1;
                if (oob(mem_req_o.addr, mem_req_o.size)) begin
                    mem_resp.error = 1'b1;
                end else if (!mem_req_o.write) begin
                    mem_resp.rvalid = 1'b1;
                    mem_resp.rdata  = rd_ext(mem_req_o.addr, mem_op_o);
                end
            end else if (stall_cnt >= 3) begin
                mem_resp.ready = 1'b1;
                if (mem_req_o.write && oob(mem_req_o.addr, mem_req_o.size)) mem_resp.error = 1'b1;
            end
        end
        if (pend && (pend_cnt == rv_wait)) begin
            if (pend_err) mem_resp.error = 1'b1;
            else begin
                mem_resp.rvalid = 1'b1;
                mem_resp.rdata  = pend_data;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
            stall_cnt <= 0;
            pend      <= 1'b0;
            pend_cnt  <= 0;
            pend_data <= '0;
            pend_err  <= 1'b0;
            pages     <= 32'd1;
            gdone     <= 1'b0;
            gres      <= '0;
        end else begin
            gdone <= 1'b0;
            if (mgmt_req.grow_valid) begin
                gdone <= 1'b1;
                if (({1'b0, pages} + {1'b0, mgmt_req.grow_pages}) <= 33'(MAX_PAGES)) begin
                    gres  <= pages;
                    pages <= pages + mgmt_req.grow_pages;
                end else begin
                    gres <= 32'hFFFF_FFFF;
                end
            end
            if (pend) begin
                if (pend_cnt == rv_wait) pend <= 1'b0;
                else pend_cnt <= pend_cnt + 1;
            end
            if (mem_req_o.valid && mem_resp.ready) begin
                stall_cnt <= 0;
                if (mem_req_o.write) begin
                    if (!mem_resp.error) begin
                        for (int i = 0; i < 8; i++)
                            if (i < (1 << mem_req_o.size))
                                mem[mem_req_o.addr[9:0] + 10'(i)] <= mem_req_o.wdata[i*8 +: 8];
                    end
                end else if (stall_mode) begin
                    pend      <= 1'b1;
                    pend_cnt  <= 0;
                    pend_err  <= oob(mem_req_o.addr, mem_req_o.size);
                    pend_data <= rd_ext(mem_req_o.addr, mem_op_o);
                end
            end else if (mem_req_o.valid) begin
                stall_cnt <= stall_cnt + 1;
            end
        end
    end

    assign mgmt_resp.current_pages = pages;
    assign mgmt_resp.grow_result   = gres;
    assign mgmt_resp.grow_done     = gdone;

    // ---------------- request monitor ----------------
    int          req_cnt = 0;
    int          grow_cnt = 0;
    logic [31:0] last_addr;
    logic [63:0] last_wdata;
    logic        last_write;

    always @(posedge clk) begin
        if (rst_n && mem_req_o.valid && mem_resp.ready) begin
            req_cnt    <= req_cnt + 1;
            last_addr  <= mem_req_o.addr;
            last_wdata <= mem_req_o.wdata;
            last_write <= mem_req_o.write;
        end
        if (rst_n && mgmt_req.grow_valid) grow_cnt <= grow_cnt + 1;
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        lsu_kind_t   kind;
        mem_op_t     op;
        logic [31:0] base;
        logic [31:0] off;
        logic [63:0] wdata;
        logic [63:0] exp_data;
        trap_t       exp_trap;
        bit          exp_req;
        logic [63:0] exp_wdata;
    } vec_t;

    task automatic issue(input lsu_kind_t k, input mem_op_t op, input logic [31:0] b,
                         input logic [31:0] o, input logic [63:0] w);
        @(negedge clk);
        cmd_kind   = k;
        cmd_op     = op;
        cmd_base   = b;
        cmd_offset = o;
        cmd_wdata  = w;
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  r0, g0;
        bit  got;
        string tag;
        tag = $sformatf("vec%0d", idx);
        r0  = req_cnt;
        g0  = grow_cnt;
        issue(v.kind, v.op, v.base, v.off, v.wdata);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (res_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_res_valid"}, 64'(got), 64'd1);
        if (!got) return;
        chk({tag, "_data"}, res_data, v.exp_data);
        chk({tag, "_trap"}, 64'(res_trap), 64'(v.exp_trap));
        chk({tag, "_req_count"}, 64'(req_cnt - r0), v.exp_req ? 64'd1 : 64'd0);
        chk({tag, "_grow_count"}, 64'(grow_cnt - g0), (v.kind == LSU_GROW) ? 64'd1 : 64'd0);
        if (v.exp_req) begin
            chk({tag, "_addr"}, 64'(last_addr), 64'(v.base + v.off));
            chk({tag, "_write"}, 64'(last_write), (v.kind == LSU_STORE) ? 64'd1 : 64'd0);
            if (v.kind == LSU_STORE) chk({tag, "_wdata"}, last_wdata, v.exp_wdata);
        end
        consume();
    endtask

    vec_t vecs [22];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_valid, n_res, r0;
        bit seen;

        //                kind       op               base          off           wdata                   exp_data                trap                req  exp_wdata
        vecs[0]  = '{LSU_STORE, OP_I32_STORE,    32'h10,       32'h4,        64'hFFFF_FFFF_DEAD_BEEF, 64'h0,                  TRAP_NONE,          1, 64'hDEAD_BEEF};
        vecs[1]  = '{LSU_LOAD,  OP_I32_LOAD,     32'h10,       32'h4,        64'h0,                   64'h0000_0000_DEAD_BEEF, TRAP_NONE,         1, 64'h0};
        vecs[2]  = '{LSU_STORE, OP_I32_STORE8,   32'h20,       32'h0,        64'h1234_5680,           64'h0,                  TRAP_NONE,          1, 64'h80};
        vecs[3]  = '{LSU_LOAD,  OP_I32_LOAD8_S,  32'h20,       32'h0,        64'h0,                   64'hFFFF_FFFF_FFFF_FF80, TRAP_NONE,         1, 64'h0};
        vecs[4]  = '{LSU_LOAD,  OP_I32_LOAD8_U,  32'h20,       32'h0,        64'h0,                   64'h80,                 TRAP_NONE,          1, 64'h0};
        vecs[5]  = '{LSU_LOAD,  OP_I32_LOAD,     32'h20,       32'h0,        64'h0,                   64'h80,                 TRAP_NONE,          1, 64'h0};
        vecs[6]  = '{LSU_STORE, OP_I64_STORE,    32'h40,       32'h8,        64'h0123_4567_89AB_CDEF, 64'h0,                  TRAP_NONE,          1, 64'h0123_4567_89AB_CDEF};
        vecs[7]  = '{LSU_LOAD,  OP_I64_LOAD,     32'h48,       32'h0,        64'h0,                   64'h0123_4567_89AB_CDEF, TRAP_NONE,         1, 64'h0};
        vecs[8]  = '{LSU_LOAD,  OP_I64_LOAD16_S, 32'h40,       32'h8,        64'h0,                   64'hFFFF_FFFF_FFFF_CDEF, TRAP_NONE,         1, 64'h0};
        vecs[9]  = '{LSU_LOAD,  OP_I64_LOAD32_U, 32'h4C,       32'h0,        64'h0,                   64'h0000_0000_0123_4567, TRAP_NONE,         1, 64'h0};
        vecs[10] = '{LSU_LOAD,  OP_I32_LOAD,     32'hFFFF_FFF0, 32'h20,      64'h0,                   64'h0,                  TRAP_OUT_OF_BOUNDS, 0, 64'h0};
        vecs[11] = '{LSU_STORE, OP_I32_STORE16,  32'hFFFF_0000, 32'h0001_0000, 64'h1,                 64'h0,                  TRAP_OUT_OF_BOUNDS, 0, 64'h0};
        vecs[12] = '{LSU_LOAD,  OP_I32_LOAD,     32'h0,        32'hFFFE,     64'h0,                   64'h0,                  TRAP_OUT_OF_BOUNDS, 1, 64'h0};
        vecs[13] = '{LSU_LOAD,  OP_I32_LOAD8_U,  32'hFFFF_FFFF, 32'h0,       64'h0,                   64'h0,                  TRAP_OUT_OF_BOUNDS, 1, 64'h0};
        vecs[14] = '{LSU_STORE, OP_I32_STORE,    32'h0,        32'hFFFE,     64'h55,                  64'h0,                  TRAP_OUT_OF_BOUNDS, 1, 64'h55};
        vecs[15] = '{LSU_SIZE,  OP_I32_LOAD,     32'h0,        32'h0,        64'h0,                   64'h1,                  TRAP_NONE,          0, 64'h0};
        vecs[16] = '{LSU_GROW,  OP_I32_LOAD,     32'h0,        32'h0,        64'h2,                   64'h1,                  TRAP_NONE,          0, 64'h0};
        vecs[17] = '{LSU_SIZE,  OP_I32_LOAD,     32'h0,        32'h0,        64'h0,                   64'h3,                  TRAP_NONE,          0, 64'h0};
        vecs[18] = '{LSU_GROW,  OP_I32_LOAD,     32'h0,        32'h0,        64'h5,                   64'hFFFF_FFFF,          TRAP_NONE,          0, 64'h0};
        vecs[19] = '{LSU_SIZE,  OP_I32_LOAD,     32'h0,        32'h0,        64'h0,                   64'h3,                  TRAP_NONE,          0, 64'h0};
        vecs[20] = '{LSU_LOAD,  OP_I32_LOAD,     32'h0002_0000, 32'hFFFC,    64'h0,                   64'h0,                  TRAP_NONE,          1, 64'h0};
        vecs[21] = '{LSU_LOAD,  OP_I32_LOAD,     32'h0002_0000, 32'hFFFE,    64'h0,                   64'h0,                  TRAP_OUT_OF_BOUNDS, 1, 64'h0};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_data", res_data, 64'd0);
        chk("rst_res_trap", 64'(res_trap), 64'(TRAP_NONE));
        chk("rst_mem_req", 64'(mem_req_o.valid) | 64'(mem_req_o.write) | 64'(mem_req_o.addr)
                           | 64'(mem_req_o.size) | mem_req_o.wdata, 64'd0);
        chk("rst_mgmt_req", 64'(mgmt_req.grow_valid) | 64'(mgmt_req.grow_pages)
                            | 64'(mgmt_req.init_valid), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) run_vec(i, vecs[i]);

        // Zero-wait load latency: accept edge 0, request in cycle 1, result in cycle 2.
        @(negedge clk);
        chk("lat_cmd_ready", 64'(cmd_ready), 64'd1);
        cmd_kind   = LSU_LOAD;
        cmd_op     = OP_I32_LOAD8_U;
        cmd_base   = 32'h1C;
        cmd_offset = 32'h4;
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("lat_req_valid_c1", 64'(mem_req_o.valid), 64'd1);
        chk("lat_req_addr_c1", 64'(mem_req_o.addr), 64'h20);
        chk("lat_req_size_c1", 64'(mem_req_o.size), 64'(SZ_1));
        chk("lat_res_valid_c1", 64'(res_valid), 64'd0);
        chk("lat_cmd_ready_c1", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        chk("lat_res_valid_c2", 64'(res_valid), 64'd1);
        chk("lat_res_data_c2", res_data, 64'h80);
        chk("lat_req_valid_c2", 64'(mem_req_o.valid), 64'd0);
        // Result must hold while the consumer stalls.
        @(negedge clk);
        chk("lat_res_hold_valid", 64'(res_valid), 64'd1);
        chk("lat_res_hold_data", res_data, 64'h80);
        consume();

        // Stalling responder: ready low 3 cycles, rvalid 2 cycles after acceptance.
        @(negedge clk);
        stall_mode = 1'b1;
        rv_wait    = 1;
        r0         = req_cnt;
        n_valid    = 0;
        seen       = 1'b0;
        issue(LSU_LOAD, OP_I32_LOAD, 32'h10, 32'h4, 64'h0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req_o.valid) begin
                n_valid++;
                chk("stall_addr", 64'(mem_req_o.addr), 64'h14);
                chk("stall_size", 64'(mem_req_o.size), 64'(SZ_4));
                chk("stall_write", 64'(mem_req_o.write), 64'd0);
            end
            if (res_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("stall_res_seen", 64'(seen), 64'd1);
        chk("stall_valid_cycles", 64'(n_valid), 64'd4);
        chk("stall_req_count", 64'(req_cnt - r0), 64'd1);
        chk("stall_data", res_data, 64'h0000_0000_DEAD_BEEF);
        chk("stall_trap", 64'(res_trap), 64'(TRAP_NONE));
        consume();
        n_res = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (res_valid) n_res++;
        end
        chk("stall_single_result", 64'(n_res), 64'd0);
        chk("stall_back_idle", 64'(cmd_ready), 64'd1);

        // Reset while waiting for read data: no result may ever appear.
        rv_wait = 50;
        r0      = req_cnt;
        issue(LSU_LOAD, OP_I32_LOAD, 32'h10, 32'h4, 64'h0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_cnt != r0) break;
        end
        chk("rstw_req_accepted", 64'(req_cnt - r0), 64'd1);
        @(negedge clk);
        chk("rstw_in_wait_valid", 64'(mem_req_o.valid), 64'd0);
        chk("rstw_in_wait_res", 64'(res_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("rstw_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rstw_res_valid", 64'(res_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_res = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (res_valid) n_res++;
        end
        chk("rstw_no_result", 64'(n_res), 64'd0);
        chk("rstw_idle", 64'(cmd_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
